// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops the FIFO under a credit rule, tracks reads in flight
// across the RAM read latency and re-times returned words into a valid/ready stream.
module fifo_rd_stream #(
    parameter int WIDTH    = 8,
    parameter int RDLAT    = 1,
    parameter int BUFDEPTH = 4,
    parameter int CNTWIDTH = 16
) (
    input  logic                      rdclk,
    input  logic                      reset,
    output logic                      fifo_rd,
    input  logic                      fifo_empty,
    input  logic [WIDTH-1:0]          fifo_dataout,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [WIDTH-1:0]          m_data,
    input  logic                      flush,
    output logic [$clog2(BUFDEPTH):0] level,
    output logic [CNTWIDTH-1:0]       xfer_count
);
    localparam int PW = $clog2(BUFDEPTH);
    localparam int LW = PW + 1;
    localparam int CW = LW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUFDEPTH);
    localparam logic [LW-1:0] FULL_C  = LW'(BUFDEPTH);

    logic [WIDTH-1:0]    mem_q [BUFDEPTH];
    logic [WIDTH-1:0]    mem_d [BUFDEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [RDLAT-1:0]    inflight_q, inflight_d;
    logic [RDLAT-1:0]    keep_q, keep_d;
    logic [CNTWIDTH-1:0] xfer_q, xfer_d;
    logic [CW-1:0]       inflight_cnt;
    logic                push;
    logic                pop;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RDLAT; i++) begin
            inflight_cnt = inflight_cnt + CW'(inflight_q[i]);
        end
    end

    // Credit counts every outstanding read, so the buffer can never overflow.
    assign fifo_rd    = reset && !fifo_empty &&
                        (flush || ((CW'(level_q) + inflight_cnt) < DEPTH_C));
    assign m_valid    = (level_q != '0);
    assign m_data     = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign xfer_count = xfer_q;
    assign push       = inflight_q[RDLAT-1] && keep_q[RDLAT-1] && !flush;
    assign pop        = m_valid && m_ready;

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        xfer_d        = pop ? xfer_q + CNTWIDTH'(1) : xfer_q;
        inflight_d    = '0;
        keep_d        = '0;
        inflight_d[0] = fifo_rd;
        keep_d[0]     = !flush;
        for (int i = 1; i < RDLAT; i++) begin
            inflight_d[i] = inflight_q[i-1];
            keep_d[i]     = keep_q[i-1] && !flush;
        end
        if (flush) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = fifo_dataout;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge rdclk) begin
        if (!reset) begin
            for (int i = 0; i < BUFDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            inflight_q <= '0;
            keep_q     <= '0;
            xfer_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            keep_q     <= keep_d;
            xfer_q     <= xfer_d;
        end
    end

    always_ff @(posedge rdclk) begin
        if (reset && push) begin
            assert (level_q != FULL_C);
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream (RDLAT=1, BUFDEPTH=4) with a behavioural FIFO read port;
// a second instance with a 4-bit counter shares the stimulus for the wrap check.
module tb_fifo_rd_stream;
    logic        rdclk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [7:0]  fifo_dataout;
    logic        m_ready;
    logic        flush;
    logic        fifo_rd, m_valid;
    logic [7:0]  m_data;
    logic [2:0]  level;
    logic [15:0] xfer_count;
    logic        fifo_rd_c4, m_valid_c4;
    logic [7:0]  m_data_c4;
    logic [2:0]  level_c4;
    logic [3:0]  xfer_c4;

    logic [7:0]  fifo_q[$];
    logic [7:0]  exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 rdclk = ~rdclk;

    fifo_rd_stream #(.WIDTH(8), .RDLAT(1), .BUFDEPTH(4), .CNTWIDTH(16)) u_dut (
        .rdclk(rdclk), .reset(reset), .fifo_rd(fifo_rd), .fifo_empty(fifo_empty),
        .fifo_dataout(fifo_dataout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .flush(flush), .level(level), .xfer_count(xfer_count)
    );

    fifo_rd_stream #(.WIDTH(8), .RDLAT(1), .BUFDEPTH(4), .CNTWIDTH(4)) u_dut_c4 (
        .rdclk(rdclk), .reset(reset), .fifo_rd(fifo_rd_c4), .fifo_empty(fifo_empty),
        .fifo_dataout(fifo_dataout), .m_valid(m_valid_c4), .m_ready(m_ready), .m_data(m_data_c4),
        .flush(flush), .level(level_c4), .xfer_count(xfer_c4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the pop request, cross the edge, then model the FIFO read port.
    task automatic step();
        logic rd_s;
        #1 rd_s = fifo_rd;
        @(posedge rdclk);
        #1;
        if (rd_s && fifo_q.size() != 0) fifo_dataout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w, input bit expect_out);
        fifo_q.push_back(w);
        if (expect_out) exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (m_valid) begin
                if (exp_q.size() != 0) chk("drain_data", m_data, exp_q.pop_front());
                else                   chk("drain_extra_word", m_valid, 0);
            end
            step();
        end
        chk("drain_words_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_xfer", xfer_count, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_c4_valid", m_valid_c4, 0);
        chk("rst_c4_level", level_c4, 0);
        chk("rst_c4_data", m_data_c4, 0);
        chk("rst_c4_rd", fifo_rd_c4, 0);
    endtask

    initial begin
        reset        = 1'b0;
        fifo_empty   = 1'b1;
        fifo_dataout = 8'h00;
        m_ready      = 1'b0;
        flush        = 1'b0;

        // Single word: pop in cycle 0, valid in cycle 2.
        do_reset();
        push_word(8'hA5, 1'b0);
        m_ready = 1'b1;
        #1;
        chk("t1_rd_c0", fifo_rd, 1);
        step();
        chk("t1_rd_c1", fifo_rd, 0);
        chk("t1_valid_c1", m_valid, 0);
        step();
        chk("t1_valid_c2", m_valid, 1);
        chk("t1_data_c2", m_data, 8'hA5);
        chk("t1_level_c2", level, 1);
        step();
        chk("t1_valid_c3", m_valid, 0);
        chk("t1_level_c3", level, 0);
        chk("t1_xfer", xfer_count, 1);
        chk("t1_xfer_c4", xfer_c4, 1);

        // Streaming: 64 words at full throughput.
        do_reset();
        for (int i = 0; i < 64; i++) push_word(8'(i), 1'b1);
        m_ready = 1'b1;
        step();
        step();
        for (int i = 0; i < 64; i++) begin
            chk("t2_valid", m_valid, 1);
            chk("t2_data", m_data, exp_q.pop_front());
            step();
        end
        chk("t2_valid_end", m_valid, 0);
        chk("t2_xfer", xfer_count, 64);
        chk("t2_xfer_c4", xfer_c4, 0);

        // Backpressure: buffer saturates, pops stop, data held.
        do_reset();
        for (int i = 0; i < 10; i++) push_word(8'(i), 1'b1);
        m_ready = 1'b0;
        repeat (20) step();
        chk("t3_level_sat", level, 4);
        chk("t3_rd_stopped", fifo_rd, 0);
        chk("t3_valid_held", m_valid, 1);
        chk("t3_data_held", m_data, 8'h00);
        chk("t3_fifo_left", fifo_q.size(), 6);
        m_ready = 1'b1;
        drain(30);
        chk("t3_xfer", xfer_count, 10);

        // Flush: 3 buffered + 1 in flight + 5 in FIFO, all discarded.
        do_reset();
        for (int i = 0; i < 9; i++) push_word(8'h10 + 8'(i), 1'b0);
        m_ready = 1'b0;
        repeat (4) step();
        chk("t4_level_pre", level, 3);
        flush = 1'b1;
        #1;
        chk("t4_rd_flush", fifo_rd, 1);
        step();
        chk("t4_level_flush", level, 0);
        chk("t4_valid_flush", m_valid, 0);
        for (int i = 0; i < 7; i++) begin
            chk("t4_valid_during", m_valid, 0);
            step();
        end
        chk("t4_fifo_drained", fifo_q.size(), 0);
        flush = 1'b0;
        step();
        step();
        chk("t4_valid_post", m_valid, 0);
        chk("t4_level_post", level, 0);
        push_word(8'h77, 1'b1);
        m_ready = 1'b1;
        drain(6);
        chk("t4_xfer", xfer_count, 1);

        // Reset mid-stream with 3 words buffered and one in flight.
        for (int i = 0; i < 10; i++) push_word(8'h20 + 8'(i), 1'b0);
        m_ready = 1'b0;
        repeat (4) step();
        chk("t5_level_pre", level, 3);
        chk("t5_data_pre", m_data, 8'h20);
        reset = 1'b0;
        #1;
        chk("t5_rd_in_reset", fifo_rd, 0);
        step();
        reset = 1'b1;
        #1;
        chk("t5_valid", m_valid, 0);
        chk("t5_level", level, 0);
        chk("t5_xfer", xfer_count, 0);
        chk("t5_xfer_c4", xfer_c4, 0);
        chk("t5_fifo_left", fifo_q.size(), 6);
        for (int i = 4; i < 10; i++) exp_q.push_back(8'h20 + 8'(i));
        m_ready = 1'b1;
        drain(15);
        chk("t5_xfer_end", xfer_count, 6);

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int i = 0; i < 17; i++) push_word(8'h40 + 8'(i), 1'b0);
        m_ready = 1'b1;
        repeat (17) step();
        chk("t6_c4_15", xfer_c4, 4'hF);
        chk("t6_main_15", xfer_count, 15);
        step();
        chk("t6_c4_16", xfer_c4, 4'h0);
        chk("t6_main_16", xfer_count, 16);
        step();
        chk("t6_c4_17", xfer_c4, 4'h1);
        chk("t6_main_17", xfer_count, 17);
        chk("t6_valid_end", m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for the dual-clock FIFO, in the rdclk domain.
- Issues FIFO pops (rd), tracks reads in flight across the RAM read latency, and captures returned words into a small prefetch buffer.
- Presents the captured words as a valid/ready stream with full throughput.
- Provides a flush/drain control and a transfer counter.

Parameters:
- WIDTH, 8, data word width; must equal the FIFO WIDTH.
- RDLAT, 1, cycles from an accepted fifo_rd to valid fifo_dataout; legal range 1..3.
- BUFDEPTH, 4, prefetch buffer entries; power of 2; must be >= RDLAT+2 for 100% throughput.
- CNTWIDTH, 16, width of xfer_count.

Ports:
- rdclk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on rdclk.
- fifo_rd  out  1  pop request to the FIFO read port.
- fifo_empty  in  1  FIFO empty flag (registered in the FIFO).
- fifo_dataout  in  WIDTH  FIFO read data; valid RDLAT cycles after the pop.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream sink ready.
- m_data  out  WIDTH  stream data.
- flush  in  1  discard buffered data and drain the FIFO while high.
- level  out  $clog2(BUFDEPTH)+1  current buffer occupancy.
- xfer_count  out  CNTWIDTH  count of completed m_valid&&m_ready handshakes.

Behaviour:
- Reset (reset==0 at an edge) clears the following: buffer occupancy, read/write pointers, in-flight pipeline valids, and xfer_count.
- After reset: m_valid=0, level=0, xfer_count=0, m_data=0.
- fifo_rd is forced to 0 combinationally while reset is low.
- Pop rule (combinational from registered state only; no m_ready->fifo_rd path):
  - Normal: fifo_rd = !fifo_empty && (level + inflight < BUFDEPTH).
  - When flush==1: fifo_rd = !fifo_empty.
  - inflight is the number of set bits in the RDLAT-stage in-flight shift register.
- In-flight tracking:
  - Stage 0 loads fifo_rd each cycle.
  - When the bit reaching stage RDLAT-1 is set, fifo_dataout is valid in that cycle and is written into the buffer at wr_ptr at the closing edge.
  - Each bit carries a keep flag; keep is 0 for pops issued during flush.
- Latency: fifo_rd high in cycle N -> fifo_dataout valid in cycle N+RDLAT -> m_valid high in cycle N+RDLAT+1 (when the buffer was empty). There is no combinational bypass.
- Buffer:
  - Circular register array with m_data = buf[rd_ptr]; m_valid = (level != 0).
  - Pop occurs on m_valid && m_ready.
  - Pointers wrap modulo BUFDEPTH.
  - A simultaneous push and pop leaves level unchanged.
  - Push never occurs when full; this is guaranteed by the credit rule. An assertion flags push while level==BUFDEPTH.
- Stream rules:
  - Once m_valid is high, m_data is held stable until the handshake.
  - m_valid does not drop without a handshake, except on flush or reset.
- Flush:
  - Cycle after flush is sampled high: level=0, m_valid=0, and all in-flight keep flags are cleared.
  - Words popped while flush is high are discarded on arrival.
  - After flush falls, normal pops resume in the same cycle. Words returning from pops issued before flush are discarded; words from pops issued after flush falls are kept.
  - xfer_count is not modified by flush.
- xfer_count increments by 1 per handshake and wraps from 2^CNTWIDTH-1 to 0.
- Reset mid-operation: in-flight words are discarded. The FIFO is reset by its own reset path; this block makes no assumption about FIFO contents after reset.
- fifo_empty deasserting while a credit is available produces fifo_rd in the same cycle.

Test Plan:
- Single word (RDLAT=1): FIFO holds 0xA5, m_ready=1 -> fifo_rd high in cycle 0; m_valid high in cycle 2 with m_data=0xA5; xfer_count=1; level returns to 0.
- Streaming: FIFO holds 0x00..0x3F (64 words), m_ready=1, BUFDEPTH=4 -> after the first-word latency, m_valid stays high for 64 consecutive cycles with in-order data; xfer_count=64.
- Backpressure: FIFO holds 10 words, m_ready=0 for 20 cycles -> level saturates at 4 and fifo_rd stays 0; m_data holds at 0x00. Releasing m_ready delivers 0x00..0x09 with no loss or duplication.
- Flush: 3 words buffered plus 1 in flight, FIFO holds 5 more, flush high 8 cycles -> level=0 and m_valid=0 the cycle after assertion; FIFO empties. After flush, a newly written 0x77 is delivered as the first word.
- Reset mid-stream: reset low for 1 cycle with level=3 -> the next cycle shows m_valid=0, level=0, xfer_count=0, fifo_rd=0 during reset; normal operation resumes afterward.
- Counter wrap (CNTWIDTH=4): 17 handshakes -> xfer_count reads 0xF after 15 and wraps to 0x0 at 16, then reads 0x1 after 17.
